multi_delay_timer: RTL

Parametrised multi-channel programmable delay/timer, the successor to the fixed one-second delay. A shared prescaler derives a tick of TICK_HZ from the system clock. N_CH independent channels each count a programmable number of ticks in one-shot, periodic or toggle (square-wave) mode. It serves the game-logic and display layers wherever timed events, blink rates or timeouts are needed.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/delay_channel.sv | 95 +++++++++
 rtl/tick_prescaler.sv | 37 +++
 rtl/multi_delay_timer.sv | 57 +++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared encodings and helpers for the multi-channel delay timer.
// Holds mode/state encodings and the clogb2 width helper.
package timer_pkg;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_TOGGLE   = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Bits needed to hold 0..value-1, never less than 1.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/delay_channel.sv
// One timer channel: one-shot, periodic or toggle countdown in ticks.
// Ports: tick/start/stop/mode/dur in; busy, done (1-cycle), wave out.
module delay_channel
  import timer_pkg::*;
#(
  parameter int DUR_W = 16
) (
  input  logic             CLOCK_50,
  input  logic             aclr,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [DUR_W-1:0] dur,
  output logic             busy,
  output logic             done,
  output logic             wave
);

  state_t           state, state_n;
  logic [DUR_W-1:0] count, count_n;
  logic [DUR_W-1:0] ldur, ldur_n;
  logic [1:0]       lmode, lmode_n;
  logic             wave_n, done_n;
  logic             start_ok;

  assign start_ok = start && (dur != '0);

  always_ff @(posedge CLOCK_50 or posedge aclr) begin
    if (aclr) begin
      state <= ST_IDLE;
      count <= '0;
      ldur  <= '0;
      lmode <= MODE_ONESHOT;
      wave  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      ldur  <= ldur_n;
      lmode <= lmode_n;
      wave  <= wave_n;
      done  <= done_n;
    end
  end

  // stop > start > expiry > decrement; only the expiry branch
  // can raise done or flip wave.
  always_comb begin
    state_n = state;
    count_n = count;
    ldur_n  = ldur;
    lmode_n = lmode;
    wave_n  = wave;
    done_n  = 1'b0;
    if (stop) begin
      state_n = ST_IDLE;
      wave_n  = 1'b0;
    end else if (start_ok) begin
      state_n = ST_RUN;
      count_n = dur;
      ldur_n  = dur;
      lmode_n = mode;
      wave_n  = 1'b0;
    end else if (start && state == ST_RUN) begin
      // zero-length restart acts as abort
      state_n = ST_IDLE;
      wave_n  = 1'b0;
    end else if (state == ST_RUN && tick) begin
      if (count == DUR_W'(1)) begin
        case (lmode)
          MODE_PERIODIC: begin
            done_n  = 1'b1;
            count_n = ldur;
          end
          MODE_TOGGLE: begin
            wave_n  = ~wave;
            count_n = ldur;
          end
          default: begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end
        endcase
      end else begin
        count_n = count - 1'b1;
      end
    end
  end

  always_comb begin
    busy = (state == ST_RUN);
  end

endmodule

// File: rtl/tick_prescaler.sv
// Prescaler: divides CLOCK_50 down to a TICK_HZ tick strobe.
// Ports: CLOCK_50, aclr, enable in; tick out (high in last pc state).
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic CLOCK_50,
  input  logic aclr,
  input  logic enable,
  output logic tick
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PC_W = clogb2(DIV);
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(DIV - 1);

  generate
    if (DIV < 1 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
      $error("tick_prescaler: CLK_HZ/TICK_HZ must be an integer >= 1");
    end
  endgenerate

  logic [PC_W-1:0] pc;

  always_ff @(posedge CLOCK_50 or posedge aclr) begin
    if (aclr) begin
      pc <= '0;
    end else if (enable) begin
      pc <= (pc == PC_MAX) ? '0 : pc + 1'b1;
    end
  end

  assign tick = enable && (pc == PC_MAX);

endmodule

// File: rtl/multi_delay_timer.sv
// Multi-channel programmable delay timer sharing one tick prescaler.
// Ports: CLOCK_50, aclr, enable, start/stop/mode/dur in; busy/done/wave/tick out.
module multi_delay_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int N_CH    = 4,
  parameter int DUR_W   = 16
) (
  input  logic                   CLOCK_50,
  input  logic                   aclr,
  input  logic                   enable,
  input  logic [N_CH-1:0]        start,
  input  logic [N_CH-1:0]        stop,
  input  logic [2*N_CH-1:0]      mode,
  input  logic [DUR_W*N_CH-1:0]  dur,
  output logic [N_CH-1:0]        busy,
  output logic [N_CH-1:0]        done,
  output logic [N_CH-1:0]        wave,
  output logic                   tick
);

  generate
    if (N_CH < 1) begin : g_bad_nch
      $error("multi_delay_timer: N_CH must be >= 1");
    end
  endgenerate

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_pre (
    .CLOCK_50 (CLOCK_50),
    .aclr     (aclr),
    .enable   (enable),
    .tick     (tick)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    delay_channel #(
      .DUR_W (DUR_W)
    ) u_ch (
      .CLOCK_50 (CLOCK_50),
      .aclr     (aclr),
      .tick     (tick),
      .start    (start[i]),
      .stop     (stop[i]),
      .mode     (mode[2*i+1:2*i]),
      .dur      (dur[DUR_W*i +: DUR_W]),
      .busy     (busy[i]),
      .done     (done[i]),
      .wave     (wave[i])
    );
  end

endmodule
